imem_loader: RTL

Boot-time program loader directly upstream of the instruction memory. It accepts a byte stream (from a UART receiver or a testbench), assembles big-endian 32-bit words, and writes them sequentially into the instruction memory's write port starting at word 0. It holds the MIPS core in reset until the whole image is written, then releases it.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_byte_packer.sv | 53 +++++
 rtl/imem_loader.sv | 135 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package global_types;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam int LOADER_BYTES_PER_WORD = 4;
    localparam int LOADER_LANE_W = $clog2(LOADER_BYTES_PER_WORD);
    localparam logic [LOADER_LANE_W-1:0] LOADER_LAST_LANE =
        LOADER_LANE_W'(LOADER_BYTES_PER_WORD - 1);

    function automatic logic len_fits(
        input logic [15:0] n,
        input int unsigned depth
    );
        return 32'(n) <= depth;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: shifts stream bytes MSB-first into a 32-bit word and
// pulses word_valid_o for one cycle once the fourth lane is filled.
module byte_packer
    import global_types::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     take_i,
    input  logic [7:0]               data_i,
    output logic [LOADER_LANE_W-1:0] lane_o,
    output logic                     word_valid_o,
    output logic [31:0]              word_o
);

    logic [LOADER_LANE_W-1:0] lane_q, lane_d;
    logic [31:0]              shift_q, shift_d;
    logic [31:0]              word_q, word_d;
    logic                     valid_q, valid_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        if (take_i) begin
            shift_d = {shift_q[23:0], data_i};
            lane_d  = lane_q + 1'b1;
            if (lane_q == LOADER_LAST_LANE) begin
                valid_d = 1'b1;
                word_d  = shift_d;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lane_q  <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign lane_o       = lane_q;
    assign word_valid_o = valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a length-prefixed byte stream into imem, holding the core
// in reset until done. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module imem_loader
    import global_types::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              core_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CHECK;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    loader_state_t            state_q;
    logic [7:0]               len_hi_q;
    logic [ADDR_W:0]          n_q;
    logic [ADDR_W:0]          words_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     core_reset_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]               csum_q;
`endif

    logic                     take;
    logic                     pack_take;
    logic [15:0]              len_w;
    logic [LOADER_LANE_W-1:0] lane;
    logic                     word_valid;
    logic [31:0]              word;

    assign rx_ready  = (state_q == LEN_HI) || (state_q == LEN_LO)
                    || (state_q == DATA)   || (state_q == CHECK);
    assign take      = rx_valid && rx_ready;
    assign pack_take = take && (state_q == DATA);
    assign len_w     = {len_hi_q, rx_data};

    byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .take_i       (pack_take),
        .data_i       (rx_data),
        .lane_o       (lane),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= LEN_HI;
            len_hi_q     <= '0;
            n_q          <= '0;
            words_q      <= '0;
            addr_q       <= '0;
            core_reset_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            core_reset_q <= (state_q != DONE);
            // Address advances after each write except the last one.
            if (word_valid && (words_q != n_q)) begin
                addr_q <= addr_q + 1'b1;
            end
            unique case (state_q)
                LEN_HI: begin
                    if (take) begin
                        len_hi_q <= rx_data;
                        state_q  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (take) begin
                        if (len_w == 16'd0) begin
                            state_q <= AFTER_DATA;
                        end else if (!len_fits(len_w, DEPTH)) begin
                            state_q <= ERROR;
                        end else begin
                            n_q     <= len_w[ADDR_W:0];
                            state_q <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (pack_take) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                        if (lane == LOADER_LAST_LANE) begin
                            if (words_q < n_q) begin
                                words_q <= words_q + 1'b1;
                            end
                            if (words_q == n_q - 1'b1) begin
                                state_q <= AFTER_DATA;
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (take) begin
                        state_q <= (rx_data == csum_q) ? DONE : ERROR;
                    end
                end
`endif
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign imem_we      = word_valid;
    assign imem_addr    = addr_q;
    assign imem_wd      = word;
    assign core_reset   = core_reset_q;
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign words_loaded = words_q;

endmodule
